keyboard_event_queue: RTL and testbench
=======================================

KEYBOARD_EVENT_QUEUE -- requirements
Module: keyboard_event_queue

Interface
REQ-001 Parameter WIDTH, default 8: width of the raw key-value bus and of the event data.
REQ-002 Parameter CLOCKDIVISOR, default 1000: clk cycles per sample tick; minimum 2.
REQ-003 Parameter STEADYTICKS, default 8: consecutive matching ticks required before a value counts as stable; range 1..255.
REQ-004 Parameter DEPTH, default 4: event FIFO entries; power of 2, minimum 2.
REQ-005 Parameter REPEATENABLE, default 1: 1 enables auto-repeat; 0 disables it.
REQ-006 Parameter REPEATDELAY, default 50: ticks from a press event to the first repeat; minimum 1.
REQ-007 Parameter REPEATPERIOD, default 10: ticks between subsequent repeats; minimum 1.
REQ-008 clk, input, 1: the only clock; all state updates on its rising edge.
REQ-009 RST, input, 1: synchronous, active-high reset.
REQ-010 keyValues, input, WIDTH: raw, possibly bouncing key bus; already synchronised to clk.
REQ-011 eventReady, input, 1: consumer accepts the head event.
REQ-012 clearOverflow, input, 1: clears the overflow flag.
REQ-013 eventData, output, WIDTH: head-of-FIFO key value; 0 means all keys released.
REQ-014 eventRepeat, output, 1: head event is an auto-repeat, not a change.
REQ-015 eventValid, output, 1: FIFO is non-empty.
REQ-016 eventCount, output, $clog2(DEPTH)+1: current FIFO occupancy.
REQ-017 savedByte, output, WIDTH: last debounced stable value.
REQ-018 overflow, output, 1: sticky flag; set when an event is dropped.

Function
REQ-019 Tick divider: counter runs 0..CLOCKDIVISOR-1 and wraps to 0; tick is high for one cycle when counter==CLOCKDIVISOR-1.
REQ-020 On a tick with keyValues!=testingValue: testingValue<=keyValues and steadyCount<=0.
REQ-021 On a tick with keyValues==testingValue: steadyCount increments, saturating at STEADYTICKS.
REQ-022 Qualifying tick: a matching tick on which steadyCount goes from STEADYTICKS-1 to STEADYTICKS.
REQ-023 Change event: on a qualifying tick with testingValue!=savedByte, savedByte<=testingValue, push {data=testingValue, repeat=0}, and reset the repeat counter.
REQ-024 Non-tick cycles never change testingValue, steadyCount, savedByte or the repeat counter.
REQ-025 Auto-repeat (REPEATENABLE=1) runs only while savedByte!=0 and steadyCount==STEADYTICKS.
REQ-026 Auto-repeat timing: counts ticks from the change event; first repeat push {data=savedByte, repeat=1} at tick REPEATDELAY, then every REPEATPERIOD ticks.
REQ-027 A mismatch tick or a new change event restarts the repeat schedule from zero; with REPEATENABLE=0 no repeat event is ever pushed.
REQ-028 At most one push per cycle; a change event and a repeat never coincide.
REQ-029 Pop occurs when eventValid && eventReady; eventReady while empty is ignored.
REQ-030 Latency: an event pushed on edge N is visible on eventData/eventRepeat with eventValid=1 from cycle N+1; outputs come directly from the FIFO head register/array (no combinational path from keyValues).
REQ-031 Push with FIFO not full: accepted.
REQ-032 Push with FIFO full and no pop that cycle: event dropped, FIFO unchanged, overflow<=1.
REQ-033 Push with FIFO full and a pop that cycle: both occur, occupancy stays DEPTH, order preserved.
REQ-034 Push and pop with FIFO empty: push accepted, pop ignored.
REQ-035 FIFO pointers wrap modulo DEPTH; eventCount is the exact occupancy, 0..DEPTH.
REQ-036 Overflow set has priority over clearOverflow in the same cycle; otherwise clearOverflow drives overflow to 0.

Reset
REQ-037 While RST=1 at a clk edge: divider, testingValue, steadyCount, savedByte, repeat counter, FIFO pointers and overflow become 0.
REQ-038 After reset: eventValid=0, eventCount=0, eventData=0, eventRepeat=0, overflow=0, savedByte=0.
REQ-039 Reset asserted mid-debounce or with a non-empty FIFO discards all pending state and events; no event is generated by reset itself.

Verification (CLOCKDIVISOR=4, STEADYTICKS=3, DEPTH=4, REPEATDELAY=5, REPEATPERIOD=2)
REQ-040 Release reset, hold keyValues=0x41 -> exactly one event {0x41, repeat=0} on the 4th tick after the change; savedByte=0x41; eventCount=1.
REQ-041 Toggle 0x41/0x00 every 3 cycles for 40 cycles, then hold 0x00 -> no event while toggling; at most one release event {0x00} after settling if savedByte was nonzero.
REQ-042 Hold 0x41 with eventReady=1 -> repeats {0x41, repeat=1} at 5 ticks after the press, then every 2 ticks; releasing to 0x00 stops repeats and yields one {0x00, repeat=0}.
REQ-043 eventReady=0, generate 6 distinct stable changes -> eventCount=4, first four events retained in order, overflow=1; clearOverflow pulse -> overflow=0.
REQ-044 FIFO full, push and eventReady=1 in the same cycle -> eventCount stays 4, head advances, new event appended last, overflow stays 0.
REQ-045 Assert RST for 1 cycle with 3 queued events and the debounce mid-count -> all outputs at reset values next cycle; a held key re-debounces from zero.

Source files
------------

// File: rtl/keyboard_event_queue.sv
// keyboard_event_queue: debounces a raw key bus on a divided sample tick and queues change/auto-repeat events in a FIFO.
module keyboard_event_queue #(
   parameter int WIDTH        = 8,
   parameter int CLOCKDIVISOR = 1000,
   parameter int STEADYTICKS  = 8,
   parameter int DEPTH        = 4,
   parameter int REPEATENABLE = 1,
   parameter int REPEATDELAY  = 50,
   parameter int REPEATPERIOD = 10
) (
   input  logic                     clk,
   input  logic                     RST,
   input  logic [WIDTH-1:0]         keyValues,
   input  logic                     eventReady,
   input  logic                     clearOverflow,
   output logic [WIDTH-1:0]         eventData,
   output logic                     eventRepeat,
   output logic                     eventValid,
   output logic [$clog2(DEPTH):0]   eventCount,
   output logic [WIDTH-1:0]         savedByte,
   output logic                     overflow
);
   localparam int DW = $clog2(CLOCKDIVISOR);
   localparam int AW = $clog2(DEPTH);
   localparam int RW = $clog2((REPEATDELAY > REPEATPERIOD ? REPEATDELAY : REPEATPERIOD) + 1);

   logic [DW-1:0]    div_q, div_d;
   logic [WIDTH-1:0] testing_q, testing_d, saved_q, saved_d;
   logic [7:0]       steady_q, steady_d;
   logic [RW-1:0]    rep_q, rep_d, rep_inc, rep_target;
   logic             period_q, period_d;
   logic [WIDTH-1:0] data_q [DEPTH];
   logic [DEPTH-1:0] rpt_q;
   logic [AW-1:0]    wr_q, rd_q;
   logic [AW:0]      cnt_q;
   logic             ovf_q;
   logic             tick, match, restart, change, active, push_rpt, push, pop, full, accept;

   always_comb begin
      tick       = div_q == DW'(CLOCKDIVISOR - 1);
      div_d      = tick ? '0 : div_q + 1'b1;
      match      = keyValues == testing_q;
      change     = tick && match && steady_q == 8'(STEADYTICKS - 1) && testing_q != saved_q;
      active     = REPEATENABLE != 0 && saved_q != '0 && steady_q == 8'(STEADYTICKS);
      rep_inc    = rep_q + 1'b1;
      // after the first repeat the schedule switches from the initial delay to the period
      rep_target = period_q ? RW'(REPEATPERIOD) : RW'(REPEATDELAY);
      push_rpt   = tick && match && active && rep_inc == rep_target;
      push       = change || push_rpt;
      restart    = !match || change;
      testing_d  = tick && !match ? keyValues : testing_q;
      steady_d   = !tick ? steady_q : !match ? '0 : steady_q == 8'(STEADYTICKS) ? steady_q : steady_q + 1'b1;
      saved_d    = change ? testing_q : saved_q;
      rep_d      = !tick ? rep_q : (restart || push_rpt) ? '0 : active ? rep_inc : rep_q;
      period_d   = !tick ? period_q : restart ? 1'b0 : push_rpt ? 1'b1 : period_q;
      full       = cnt_q == (AW+1)'(DEPTH);
      pop        = cnt_q != '0 && eventReady;
      accept     = push && (!full || pop);
   end

   always_ff @(posedge clk) begin
      if (RST) begin
         div_q     <= '0;
         testing_q <= '0;
         steady_q  <= '0;
         saved_q   <= '0;
         rep_q     <= '0;
         period_q  <= 1'b0;
         wr_q      <= '0;
         rd_q      <= '0;
         cnt_q     <= '0;
         ovf_q     <= 1'b0;
      end else begin
         div_q     <= div_d;
         testing_q <= testing_d;
         steady_q  <= steady_d;
         saved_q   <= saved_d;
         rep_q     <= rep_d;
         period_q  <= period_d;
         if (accept) begin
            data_q[wr_q] <= push_rpt ? saved_q : testing_q;
            rpt_q[wr_q]  <= push_rpt;
            wr_q         <= wr_q + 1'b1;
         end
         if (pop) rd_q <= rd_q + 1'b1;
         cnt_q <= cnt_q + (AW+1)'(accept) - (AW+1)'(pop);
         ovf_q <= (push && full && !pop) ? 1'b1 : clearOverflow ? 1'b0 : ovf_q;
      end
   end

   assign eventValid  = cnt_q != '0;
   assign eventData   = eventValid ? data_q[rd_q] : '0;
   assign eventRepeat = eventValid && rpt_q[rd_q];
   assign eventCount  = cnt_q;
   assign savedByte   = saved_q;
   assign overflow    = ovf_q;
endmodule

// File: tb/tb_keyboard_event_queue.sv
// tb_keyboard_event_queue: random and directed stimulus against a sample-run/queue reference model.
module tb_keyboard_event_queue;
   localparam int CD = 4, ST = 3, DP = 4, RD = 5, RP = 2;

   logic       clk = 0, RST = 1, eventReady = 0, clearOverflow = 0;
   logic [7:0] keyValues = 0;
   logic [7:0] eventData, savedByte;
   logic       eventRepeat, eventValid, overflow;
   logic [2:0] eventCount;

   keyboard_event_queue #(.WIDTH(8), .CLOCKDIVISOR(CD), .STEADYTICKS(ST), .DEPTH(DP),
      .REPEATENABLE(1), .REPEATDELAY(RD), .REPEATPERIOD(RP)) dut (
      .clk(clk), .RST(RST), .keyValues(keyValues), .eventReady(eventReady),
      .clearOverflow(clearOverflow), .eventData(eventData), .eventRepeat(eventRepeat),
      .eventValid(eventValid), .eventCount(eventCount), .savedByte(savedByte), .overflow(overflow));

   always #5 clk = ~clk;

   typedef struct packed {logic [7:0] d; logic r;} ev_t;
   ev_t        q[$];
   int         m_div, m_len;
   logic [7:0] m_val, m_saved;
   logic       m_ovf;
   int         vectors = 0, miscompares = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic void model_reset();
      m_div = 0; m_val = 0; m_len = 1; m_saved = 0; m_ovf = 0;
      q.delete();
   endfunction

   // run length counts consecutive equal samples; stable at ST+1, repeats k ticks later
   function automatic bit next_event(output ev_t e);
      int len, k;
      e = '0;
      if (m_div != CD - 1) return 0;
      len = (keyValues == m_val) ? m_len + 1 : 1;
      if (len == ST + 1 && keyValues != m_saved) begin
         e = {keyValues, 1'b0};
         return 1;
      end
      k = len - (ST + 1);
      if (m_saved != 0 && k >= RD && (k - RD) % RP == 0) begin
         e = {m_saved, 1'b1};
         return 1;
      end
      return 0;
   endfunction

   function automatic void model_step();
      ev_t e;
      bit  p, full, pop;
      p = next_event(e);
      if (m_div == CD - 1) begin
         if (keyValues == m_val) m_len++;
         else begin m_val = keyValues; m_len = 1; end
         if (p && !e.r) m_saved = e.d;
      end
      m_div = (m_div + 1) % CD;
      full = q.size() == DP;
      pop  = q.size() != 0 && eventReady;
      if (pop) void'(q.pop_front());
      if (p) begin
         if (full && !pop) m_ovf = 1;
         else q.push_back(e);
      end
      if (!(p && full && !pop) && clearOverflow) m_ovf = 0;
   endfunction

   task automatic cyc();
      ev_t h;
      @(posedge clk);
      if (RST) model_reset(); else model_step();
      #1;
      h = q.size() != 0 ? q[0] : '0;
      chk("valid", 32'(eventValid), 32'(q.size() != 0));
      chk("count", 32'(eventCount), 32'(q.size()));
      chk("data", 32'(eventData), 32'(h.d));
      chk("repeat", 32'(eventRepeat), 32'(h.r));
      chk("saved", 32'(savedByte), 32'(m_saved));
      chk("overflow", 32'(overflow), 32'(m_ovf));
   endtask

   task automatic run(input int n, input logic [7:0] k, input logic rdy);
      keyValues = k; eventReady = rdy;
      repeat (n) cyc();
   endtask

   initial begin
      int rpts, seen;
      ev_t e;
      RST = 1; repeat (3) cyc(); RST = 0;
      chk("rst_count", 32'(eventCount), 0);
      chk("rst_data", 32'(eventData), 0);
      // single press: event at the 4th sample, before any repeat is due
      run(30, 8'h41, 0);
      chk("press_count", 32'(eventCount), 1);
      chk("press_data", 32'(eventData), 32'h41);
      chk("press_saved", 32'(savedByte), 32'h41);
      run(1, 8'h41, 1);
      for (int i = 0; i < 40; i++) begin
         keyValues = ((i / 3) % 2) != 0 ? 8'h00 : 8'h41; eventReady = 1;
         cyc();
      end
      run(40, 8'h00, 1);
      chk("toggle_saved", 32'(savedByte), 0);
      rpts = 0;
      keyValues = 8'h41;
      for (int i = 0; i < 100; i++) begin
         cyc();
         if (eventValid && eventRepeat) rpts++;
      end
      chk("rpt_seen", 32'(rpts > 3), 1);
      run(40, 8'h00, 1);
      chk("release_saved", 32'(savedByte), 0);
      chk("release_count", 32'(eventCount), 0);
      for (int i = 0; i < 6; i++) run(20, 8'h11 + 8'(i), 0);
      chk("ovf_count", 32'(eventCount), 4);
      chk("ovf_flag", 32'(overflow), 1);
      keyValues = 8'h00; clearOverflow = 1; cyc(); clearOverflow = 0;
      chk("ovf_clear", 32'(overflow), 0);
      for (int i = 0; i < 4; i++) begin
         chk("ovf_order", 32'(eventData), 32'h11 + i);
         eventReady = 1; cyc(); eventReady = 0;
      end
      run(40, 8'h00, 1);
      for (int i = 0; i < 4; i++) run(20, 8'h21 + 8'(i), 0);
      chk("full_count", 32'(eventCount), 4);
      keyValues = 8'h25; seen = 0;
      for (int i = 0; i < 40 && seen == 0; i++) begin
         eventReady = next_event(e);
         cyc();
         if (eventReady) begin
            seen = 1;
            chk("fullpp_count", 32'(eventCount), 4);
            chk("fullpp_head", 32'(eventData), 32'h22);
            chk("fullpp_ovf", 32'(overflow), 0);
         end
      end
      chk("fullpp_seen", 32'(seen), 1);
      run(40, 8'h00, 1);
      for (int i = 0; i < 3; i++) run(20, 8'h31 + 8'(i), 0);
      run(6, 8'h34, 0);
      RST = 1; cyc(); RST = 0;
      chk("midrst_valid", 32'(eventValid), 0);
      chk("midrst_saved", 32'(savedByte), 0);
      run(12, 8'h34, 0);
      chk("redeb_early", 32'(eventCount), 0);
      run(8, 8'h34, 0);
      chk("redeb_count", 32'(eventCount), 1);
      chk("redeb_data", 32'(eventData), 32'h34);
      for (int b = 0; b < 120; b++) begin
         int n;
         n = $urandom_range(1, 30);
         case ($urandom_range(0, 3))
            0: keyValues = 8'h00;
            1: keyValues = 8'h41;
            2: keyValues = 8'h42;
            default: keyValues = 8'($urandom);
         endcase
         for (int i = 0; i < n; i++) begin
            eventReady    = $urandom_range(0, 3) == 0;
            clearOverflow = $urandom_range(0, 30) == 0;
            RST           = $urandom_range(0, 499) == 0;
            if ($urandom_range(0, 9) == 0) keyValues = 8'($urandom);
            cyc();
         end
      end
      RST = 0; clearOverflow = 0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
